// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds four BCD digits from a multiplexed active-low seven-segment bus,
// tracks display blanking and measures the flash period.
module seg_scan_decoder #(
    parameter int SETTLE    = 2,
    parameter int BLANK_CYC = 8,
    parameter int PW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [6:0]    seg_vector,
    input  logic          a1,
    input  logic          a2,
    input  logic          a3,
    input  logic          a4,
    input  logic          err_clr,
    output logic [3:0]    val1,
    output logic [3:0]    val2,
    output logic [3:0]    val3,
    output logic [3:0]    val4,
    output logic          frame_valid,
    output logic          display_on,
    output logic [PW-1:0] flash_period,
    output logic          period_valid,
    output logic          seg_err,
    output logic          multi_err
);
    localparam int SW = $clog2(SETTLE + 2);
    localparam int BW = $clog2(BLANK_CYC + 1);
    // synchroniser resets to an idle bus so no phantom multi-anode cycle follows reset
    localparam logic [11:0] IDLE = {1'b0, 4'hF, 7'h7F};

    logic [11:0]      s1_q, s2_q;
    logic [6:0]       seg, key_seg_q, key_seg_d;
    logic [3:0]       low, dig, mask_q, mask_d, mask_set;
    logic [1:0]       idx, key_idx_q, key_idx_d;
    logic             clr, multi, strobe, capture, full, blank, rise;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    dark_q, dark_d;
    logic [3:0][3:0]  shadow_q, shadow_d, val_q, val_d;
    logic             frame_valid_q, frame_valid_d, display_on_q, display_on_d;
    logic             period_valid_q, period_valid_d, seen_q, seen_d;
    logic             seg_err_q, seg_err_d, multi_err_q, multi_err_d;
    logic [PW-1:0]    per_q, per_d, flash_q, flash_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q           <= IDLE;
            s2_q           <= IDLE;
            key_seg_q      <= '0;
            key_idx_q      <= '0;
            cnt_q          <= '0;
            dark_q         <= '0;
            mask_q         <= '0;
            shadow_q       <= '0;
            val_q          <= '0;
            frame_valid_q  <= 1'b0;
            display_on_q   <= 1'b0;
            period_valid_q <= 1'b0;
            seen_q         <= 1'b0;
            seg_err_q      <= 1'b0;
            multi_err_q    <= 1'b0;
            per_q          <= '0;
            flash_q        <= '0;
        end else begin
            s1_q           <= {err_clr, a4, a3, a2, a1, seg_vector};
            s2_q           <= s1_q;
            key_seg_q      <= key_seg_d;
            key_idx_q      <= key_idx_d;
            cnt_q          <= cnt_d;
            dark_q         <= dark_d;
            mask_q         <= mask_d;
            shadow_q       <= shadow_d;
            val_q          <= val_d;
            frame_valid_q  <= frame_valid_d;
            display_on_q   <= display_on_d;
            period_valid_q <= period_valid_d;
            seen_q         <= seen_d;
            seg_err_q      <= seg_err_d;
            multi_err_q    <= multi_err_d;
            per_q          <= per_d;
            flash_q        <= flash_d;
        end
    end

    always_comb begin
        seg    = s2_q[6:0];
        low    = ~s2_q[10:7];
        clr    = s2_q[11];
        multi  = (low & (low - 4'd1)) != 4'd0;
        strobe = (low != 4'd0) && !multi && (seg != 7'h7F);
        idx    = low[3] ? 2'd3 : low[2] ? 2'd2 : low[1] ? 2'd1 : 2'd0;
        case (seg)
            7'h40:   dig = 4'd0;
            7'h79:   dig = 4'd1;
            7'h24:   dig = 4'd2;
            7'h30:   dig = 4'd3;
            7'h19:   dig = 4'd4;
            7'h12:   dig = 4'd5;
            7'h02:   dig = 4'd6;
            7'h78:   dig = 4'd7;
            7'h00:   dig = 4'd8;
            7'h10:   dig = 4'd9;
            default: dig = 4'hF;
        endcase
        // the dwell counter parks one above SETTLE so a steady strobe captures only once
        cnt_d = !strobe ? '0 :
                (cnt_q != '0 && idx == key_idx_q && seg == key_seg_q) ?
                    (cnt_q == SW'(SETTLE + 1) ? cnt_q : cnt_q + 1'b1) : SW'(1);
        key_idx_d      = idx;
        key_seg_d      = seg;
        capture        = strobe && cnt_d == SW'(SETTLE);
        shadow_d       = shadow_q;
        shadow_d[idx]  = capture ? dig : shadow_q[idx];
        mask_set       = capture ? 4'b0001 << idx : 4'b0000;
        dark_d         = strobe ? '0 : dark_q == BW'(BLANK_CYC) ? dark_q : dark_q + 1'b1;
        blank          = dark_d == BW'(BLANK_CYC);
        full           = (mask_q | mask_set) == 4'hF;
        mask_d         = (full || blank) ? 4'b0000 : mask_q | mask_set;
        val_d          = full ? shadow_d : val_q;
        frame_valid_d  = full;
        display_on_d   = capture | (display_on_q & ~blank);
        rise           = display_on_d & ~display_on_q;
        per_d          = rise ? PW'(1) : &per_q ? per_q : per_q + 1'b1;
        flash_d        = (rise && seen_q) ? per_q : flash_q;
        period_valid_d = rise & seen_q;
        seen_d         = seen_q | rise;
        seg_err_d      = (capture && dig == 4'hF) | (seg_err_q & ~clr);
        multi_err_d    = multi | (multi_err_q & ~clr);
    end

    assign val1         = val_q[0];
    assign val2         = val_q[1];
    assign val3         = val_q[2];
    assign val4         = val_q[3];
    assign frame_valid  = frame_valid_q;
    assign display_on   = display_on_q;
    assign flash_period = flash_q;
    assign period_valid = period_valid_q;
    assign seg_err      = seg_err_q;
    assign multi_err    = multi_err_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed display-bus scenarios plus random traffic, every cycle
// compared against a behavioural model of the decoder.
module tb_seg_scan_decoder;
    localparam int SETTLE = 2;
    localparam int BLANK  = 8;

    logic        clk = 1'b0, rst = 1'b0, err_clr = 1'b0;
    logic        a1 = 1'b1, a2 = 1'b1, a3 = 1'b1, a4 = 1'b1;
    logic [6:0]  seg_vector = 7'h7F;
    logic [3:0]  val1, val2, val3, val4;
    logic        frame_valid, display_on, period_valid, seg_err, multi_err;
    logic [15:0] flash_period;

    seg_scan_decoder #(.SETTLE(SETTLE), .BLANK_CYC(BLANK), .PW(16)) dut (
        .clk(clk), .rst(rst), .seg_vector(seg_vector),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .err_clr(err_clr),
        .val1(val1), .val2(val2), .val3(val3), .val4(val4),
        .frame_valid(frame_valid), .display_on(display_on),
        .flash_period(flash_period), .period_valid(period_valid),
        .seg_err(seg_err), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, fcnt = 0, pcnt = 0;
    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // model: inputs seen two edges late, digits tracked by dwell length and a per-digit mask
    logic [11:0] h0, h1;
    logic [3:0]  m_sh [4], m_val [4];
    bit          m_mask [4];
    bit          m_fv, m_disp, m_pv, m_se, m_me, m_seen;
    int          dwell, key, darkrun, since;
    logic [15:0] m_fp;

    task automatic model_reset();
        h0 = 12'h7FF; h1 = 12'h7FF;
        dwell = 0; key = -1; darkrun = 0; since = 0;
        m_fv = 0; m_disp = 0; m_pv = 0; m_se = 0; m_me = 0; m_seen = 0; m_fp = 0;
        for (int i = 0; i < 4; i++) begin
            m_sh[i] = 0; m_val[i] = 0; m_mask[i] = 0;
        end
    endtask

    task automatic model_step(input logic [11:0] cur);
        logic [11:0] eff;
        logic [6:0]  s;
        logic [3:0]  lows;
        int          nl, a, d;
        bit          strobe, capture, nd, clr;
        eff = h1; h1 = h0; h0 = cur;
        s = eff[6:0]; lows = ~eff[10:7]; clr = eff[11];
        nl = $countones(lows);
        a = 0;
        for (int i = 0; i < 4; i++) if (lows[i]) a = i;
        strobe = (nl == 1) && (s != 7'h7F);
        capture = 0;
        if (strobe) begin
            dwell = (dwell > 0 && key == a * 128 + int'(s)) ? dwell + 1 : 1;
            key = a * 128 + int'(s);
            capture = (dwell == SETTLE);
        end else dwell = 0;
        darkrun = strobe ? 0 : darkrun + 1;
        d = 15;
        for (int j = 0; j < 10; j++) if (pat[j] == s) d = j;
        nd = m_disp; m_fv = 0; m_pv = 0;
        if (capture) begin
            m_sh[a] = 4'(d); m_mask[a] = 1; nd = 1;
        end else if (darkrun >= BLANK) begin
            nd = 0;
            for (int i = 0; i < 4; i++) m_mask[i] = 0;
        end
        if (m_mask[0] && m_mask[1] && m_mask[2] && m_mask[3]) begin
            m_fv = 1;
            for (int i = 0; i < 4; i++) begin
                m_val[i] = m_sh[i]; m_mask[i] = 0;
            end
        end
        m_se = (capture && d == 15) || (m_se && !clr);
        m_me = (nl >= 2) || (m_me && !clr);
        if (nd && !m_disp) begin
            if (m_seen) begin
                m_fp = 16'(since); m_pv = 1;
            end
            m_seen = 1; since = 1;
        end else since = (since < 65535) ? since + 1 : 65535;
        m_disp = nd;
    endtask

    logic [36:0] dut_b;
    assign dut_b = {val1, val2, val3, val4, frame_valid, display_on, flash_period,
                    period_valid, seg_err, multi_err};

    task automatic tick(input logic [6:0] s, input logic [3:0] an, input logic c);
        seg_vector = s; {a4, a3, a2, a1} = an; err_clr = c;
        @(posedge clk);
        if (!rst) model_reset();
        else model_step({c, an, s});
        @(negedge clk);
        check("cyc", {27'b0, dut_b}, {27'b0, m_val[0], m_val[1], m_val[2], m_val[3],
                                      m_fv, m_disp, m_fp, m_pv, m_se, m_me});
        if (frame_valid) fcnt++;
        if (period_valid) pcnt++;
    endtask

    task automatic hold(input int d, input logic [6:0] s, input int n);
        for (int i = 0; i < n; i++) tick(s, ~(4'b0001 << d), 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(7'h7F, 4'hF, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    initial begin
        model_reset();
        idle(3);
        check("reset", {27'b0, dut_b}, 64'd0);
        rst = 1'b1;
        idle(2);

        fcnt = 0;
        hold(0, pat[0], 4); hold(1, pat[1], 4); hold(2, pat[5], 4); hold(3, pat[0], 4);
        idle(6);
        check("scan0150_frames", 64'(fcnt), 64'd1);
        check("scan0150_val", {48'b0, val1, val2, val3, val4}, 64'h0150);

        do_reset();
        pcnt = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 50; i++) tick(pat[(i / 4) % 10], ~(4'b0001 << ((i / 4) % 4)), 1'b0);
            check("flash_lit", 64'(display_on), 64'd1);
            if (r == 0) check("flash_first_edge", 64'(pcnt), 64'd0);
            idle(50);
            check("flash_dark", 64'(display_on), 64'd0);
        end
        check("flash_pulses", 64'(pcnt), 64'd2);
        check("flash_period", 64'(flash_period), 64'd100);

        idle(10);
        for (int i = 0; i < 4; i++) tick(7'h00, 4'b1001, 1'b0);
        idle(4);
        check("multi_set", 64'(multi_err), 64'd1);
        check("multi_nocap", 64'(display_on), 64'd0);
        tick(7'h7F, 4'hF, 1'b1);
        idle(4);
        check("multi_clr", 64'(multi_err), 64'd0);

        fcnt = 0;
        hold(0, pat[1], 4); hold(1, pat[2], 4); hold(2, pat[3], 4); hold(3, 7'h7E, 4);
        idle(6);
        check("badseg_frames", 64'(fcnt), 64'd1);
        check("badseg_val", {48'b0, val1, val2, val3, val4}, 64'h123F);
        check("badseg_err", 64'(seg_err), 64'd1);

        idle(12);
        fcnt = 0;
        for (int i = 0; i < 20; i++) tick(pat[i % 10], 4'b1110, 1'b0);
        hold(1, pat[4], 4); hold(2, pat[5], 4); hold(3, pat[6], 4);
        idle(4);
        check("glitch_nocap", 64'(fcnt), 64'd0);
        hold(0, pat[7], 4);
        idle(6);
        check("glitch_late_frames", 64'(fcnt), 64'd1);
        check("glitch_late_val", {48'b0, val1, val2, val3, val4}, 64'h7456);

        hold(0, pat[1], 4); hold(1, pat[2], 4); hold(2, pat[3], 4);
        do_reset();
        check("midrst_zero", {27'b0, dut_b}, 64'd0);
        fcnt = 0;
        for (int i = 0; i < 4; i++) hold(i, pat[9], 4);
        idle(6);
        check("midrst_frames", 64'(fcnt), 64'd1);
        check("midrst_val", {48'b0, val1, val2, val3, val4}, 64'h9999);

        for (int e = 0; e < 500; e++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 60)
                hold($urandom_range(0, 3),
                     ($urandom_range(0, 9) == 0) ? 7'($urandom) : pat[$urandom_range(0, 9)],
                     $urandom_range(1, 6));
            else if (r < 75) idle($urandom_range(1, 14));
            else if (r < 85) begin
                logic [3:0] an;
                logic [6:0] s;
                an = 4'($urandom);
                s = 7'($urandom);
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick(s, an, 1'b0);
            end else if (r < 95) tick(7'h7F, 4'hF, 1'b1);
            else do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
